// File: rtl/fb_pkg.sv
// Shared constants and types for the double-banked frame-buffer port arbiter.
package fb_pkg;

  localparam int H_RES    = 640;  // pixels per row
  localparam int V_RES    = 480;  // rows per frame
  localparam int FB_OFS_W = 19;   // per-bank pixel offset width
  localparam int COLOR_W  = 3;    // pixel colour width

  // DRAW: raster may write the back bank. WAIT_SWAP: back bank complete, hold for vblank.
  typedef enum logic {
    DRAW      = 1'b0,
    WAIT_SWAP = 1'b1
  } fb_state_e;

endpackage

// File: rtl/fb_addr_calc.sv
// Combinational pixel coordinate to bank offset mapping with range check.
module fb_addr_calc
  import fb_pkg::FB_OFS_W;
#(
  parameter int H_RES = fb_pkg::H_RES,
  parameter int V_RES = fb_pkg::V_RES
) (
  input  logic [9:0]          x,
  input  logic [9:0]          y,
  output logic [FB_OFS_W-1:0] offset,
  output logic                in_range
);

  logic [FB_OFS_W-1:0] x_ext;
  logic [FB_OFS_W-1:0] y_ext;

  assign x_ext = FB_OFS_W'(x);
  assign y_ext = FB_OFS_W'(y);

  // 640 = 512 + 128, so the common resolution needs only two shifts and an add.
  generate
    if (H_RES == 640) begin : g_shift_add
      assign offset = (y_ext << 9) + (y_ext << 7) + x_ext;
    end else begin : g_multiply
      assign offset = y_ext * FB_OFS_W'(H_RES) + x_ext;
    end
  endgenerate

  assign in_range = (x < 10'(H_RES)) && (y < 10'(V_RES));

endmodule

// File: rtl/fb_port_arbiter.sv
// Shares one single-port, double-banked frame-buffer SRAM between display reads
// (highest priority, front bank) and raster writes (back bank), and swaps banks
// at vertical blank once the rasterizer reports the back bank complete.
module fb_port_arbiter
  import fb_pkg::FB_OFS_W;
  import fb_pkg::fb_state_e;
  import fb_pkg::DRAW;
  import fb_pkg::WAIT_SWAP;
#(
  parameter int H_RES   = fb_pkg::H_RES,
  parameter int V_RES   = fb_pkg::V_RES,
  parameter int COLOR_W = fb_pkg::COLOR_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_req,
  input  logic [9:0]         wr_x,
  input  logic [9:0]         wr_y,
  input  logic [COLOR_W-1:0] wr_color,
  output logic               wr_ready,
  input  logic               raster_done,
  input  logic               disp_req,
  input  logic [9:0]         disp_x,
  input  logic [9:0]         disp_y,
  output logic [COLOR_W-1:0] disp_data,
  output logic               disp_valid,
  input  logic               vblank,
  output logic               mem_en,
  output logic               mem_we,
  output logic [19:0]        mem_addr,
  output logic [COLOR_W-1:0] mem_wdata,
  input  logic [COLOR_W-1:0] mem_rdata,
  output logic               front_buf,
  output logic               swap_pending,
  output logic [15:0]        drop_cnt
);

  fb_state_e           state_q, state_d;
  logic                front_toggle;
  logic                disp_oor_q;
  logic [FB_OFS_W-1:0] wr_ofs, rd_ofs;
  logic                wr_in_range, rd_in_range;
  logic                wr_grant;

  fb_addr_calc #(.H_RES(H_RES), .V_RES(V_RES)) u_wr_addr (
    .x        (wr_x),
    .y        (wr_y),
    .offset   (wr_ofs),
    .in_range (wr_in_range)
  );

  fb_addr_calc #(.H_RES(H_RES), .V_RES(V_RES)) u_rd_addr (
    .x        (disp_x),
    .y        (disp_y),
    .offset   (rd_ofs),
    .in_range (rd_in_range)
  );

  // Next-state and write handshake; the handshake is held low while reset is asserted.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path can infer a latch.
    state_d      = state_q;
    front_toggle = 1'b0;
    wr_ready     = 1'b0;
    case (state_q)
      DRAW: begin
        wr_ready = rst & ~disp_req;
        if (raster_done) state_d = WAIT_SWAP;
      end
      WAIT_SWAP: begin
        if (vblank) begin
          front_toggle = 1'b1;
          state_d      = DRAW;
        end
      end
      default: state_d = DRAW;
    endcase
  end

  assign wr_grant = wr_req & wr_ready;

  // Port arbitration: display read wins; an out-of-range read leaves the SRAM idle.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (disp_req) begin
      mem_en   = rst & rd_in_range;
      mem_addr = {front_buf, rd_ofs};
    end else if (wr_grant) begin
      mem_en    = rst;
      mem_we    = rst & wr_in_range;
      mem_addr  = {~front_buf, wr_ofs};
      mem_wdata = wr_color;
    end
  end

  // Bank-swap state; reset discards any pending swap.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= DRAW;
      front_buf <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignment so every flop samples pre-edge values.
      state_q <= state_d;
      if (front_toggle) front_buf <= ~front_buf;
    end
  end

  // Read-return pipeline: one-cycle SRAM latency, out-of-range reads return zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_valid <= 1'b0;
      disp_oor_q <= 1'b0;
    end else begin
      disp_valid <= disp_req;
      disp_oor_q <= disp_req & ~rd_in_range;
    end
  end

  // Saturating count of handshaken writes that fell outside the frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_cnt <= '0;
    end else if (wr_grant && !wr_in_range && drop_cnt != 16'hFFFF) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign swap_pending = (state_q == WAIT_SWAP);
  assign disp_data    = disp_oor_q ? '0 : mem_rdata;

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Directed self-checking bench for fb_port_arbiter.
module tb_fb_port_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_req;
  logic [9:0]  wr_x, wr_y;
  logic [2:0]  wr_color;
  logic        wr_ready;
  logic        raster_done;
  logic        disp_req;
  logic [9:0]  disp_x, disp_y;
  logic [2:0]  disp_data;
  logic        disp_valid;
  logic        vblank;
  logic        mem_en, mem_we;
  logic [19:0] mem_addr;
  logic [2:0]  mem_wdata;
  logic [2:0]  mem_rdata;
  logic        front_buf;
  logic        swap_pending;
  logic [15:0] drop_cnt;

  int checks = 0;
  int errors = 0;

  fb_port_arbiter dut (
    .clk          (clk),
    .rst          (rst),
    .wr_req       (wr_req),
    .wr_x         (wr_x),
    .wr_y         (wr_y),
    .wr_color     (wr_color),
    .wr_ready     (wr_ready),
    .raster_done  (raster_done),
    .disp_req     (disp_req),
    .disp_x       (disp_x),
    .disp_y       (disp_y),
    .disp_data    (disp_data),
    .disp_valid   (disp_valid),
    .vblank       (vblank),
    .mem_en       (mem_en),
    .mem_we       (mem_we),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_rdata    (mem_rdata),
    .front_buf    (front_buf),
    .swap_pending (swap_pending),
    .drop_cnt     (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; inputs are driven and outputs sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    wr_req = 1'b0; wr_x = '0; wr_y = '0; wr_color = '0;
    raster_done = 1'b0; disp_req = 1'b0; disp_x = '0; disp_y = '0;
    vblank = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    mem_rdata = 3'b110;
    wr_req = 1'b1;            // request during reset must not be handshaken
    #3;
    check("rst_mem_en",     32'(mem_en), 0);
    check("rst_wr_ready",   32'(wr_ready), 0);
    check("rst_front_buf",  32'(front_buf), 0);
    check("rst_swap_pend",  32'(swap_pending), 0);
    check("rst_disp_valid", 32'(disp_valid), 0);
    check("rst_drop_cnt",   32'(drop_cnt), 0);
    tick(); tick();
    rst = 1'b1;
    idle_inputs();
    tick();

    // Plain write (5,2) colour 5 -> back bank 1, offset 1285.
    wr_req = 1'b1; wr_x = 10'd5; wr_y = 10'd2; wr_color = 3'b101;
    #1;
    check("wr_ready",  32'(wr_ready), 1);
    check("wr_mem_en", 32'(mem_en), 1);
    check("wr_mem_we", 32'(mem_we), 1);
    check("wr_addr",   32'(mem_addr), 32'h80505);
    check("wr_wdata",  32'(mem_wdata), 5);
    tick();

    // Read and write together -> read wins on front bank 0.
    wr_x = 10'd0; wr_y = 10'd0; disp_req = 1'b1;
    #1;
    check("rd_mem_en",   32'(mem_en), 1);
    check("rd_mem_we",   32'(mem_we), 0);
    check("rd_addr",     32'(mem_addr), 0);
    check("rd_wr_ready", 32'(wr_ready), 0);
    tick();
    idle_inputs();
    #1;
    check("rd_valid", 32'(disp_valid), 1);
    check("rd_data",  32'(disp_data), 6);

    // Out-of-range read: SRAM idle, next cycle valid with zero data.
    disp_req = 1'b1; disp_x = 10'd640;
    #1;
    check("rd_oor_mem_en", 32'(mem_en), 0);
    tick();
    idle_inputs();
    #1;
    check("rd_oor_valid", 32'(disp_valid), 1);
    check("rd_oor_data",  32'(disp_data), 0);
    tick();
    check("rd_idle_valid", 32'(disp_valid), 0);

    // raster_done with a write in the same cycle: write still lands in back bank 1.
    raster_done = 1'b1; wr_req = 1'b1; wr_x = 10'd1; wr_y = 10'd1; wr_color = 3'b011;
    #1;
    check("done_wr_ready", 32'(wr_ready), 1);
    check("done_wr_addr",  32'(mem_addr), 32'h80281);
    tick();
    raster_done = 1'b0;
    for (int i = 0; i < 10; i++) begin
      #1;
      check("wait_swap_pend", 32'(swap_pending), 1);
      check("wait_wr_ready",  32'(wr_ready), 0);
      check("wait_mem_en",    32'(mem_en), 0);
      check("wait_front",     32'(front_buf), 0);
      tick();
    end
    vblank = 1'b1;
    #1;
    check("vb_wr_ready_held", 32'(wr_ready), 0);
    tick();
    #1;
    check("swap_front",     32'(front_buf), 1);
    check("swap_pend_clr",  32'(swap_pending), 0);
    check("swap_wr_resume", 32'(wr_ready), 1);
    check("swap_wr_addr",   32'(mem_addr), 32'h00281);
    idle_inputs();
    tick();

    // raster_done with vblank together: one WAIT_SWAP cycle, then toggle.
    raster_done = 1'b1; vblank = 1'b1;
    tick();
    raster_done = 1'b0; disp_req = 1'b1;
    #1;
    check("dual_pend",      32'(swap_pending), 1);
    check("dual_front_old", 32'(front_buf), 1);
    check("dual_rd_oldbank", 32'(mem_addr), 32'h80000);
    tick();
    disp_req = 1'b0; vblank = 1'b0;
    wr_req = 1'b1; wr_x = 10'd639; wr_y = 10'd479; wr_color = 3'b111;
    #1;
    check("dual_front_new", 32'(front_buf), 0);
    check("dual_pend_clr",  32'(swap_pending), 0);
    check("corner_we",      32'(mem_we), 1);
    check("corner_addr",    32'(mem_addr), 32'hCAFFF);
    tick();

    // Out-of-range writes are handshaken but dropped.
    wr_x = 10'd640; wr_y = 10'd0;
    #1;
    check("drop_x_ready", 32'(wr_ready), 1);
    check("drop_x_en",    32'(mem_en), 1);
    check("drop_x_we",    32'(mem_we), 0);
    tick();
    wr_x = 10'd0; wr_y = 10'd480;
    #1;
    check("drop_y_ready", 32'(wr_ready), 1);
    check("drop_y_we",    32'(mem_we), 0);
    tick();
    wr_req = 1'b0;
    #1;
    check("drop_cnt_2", 32'(drop_cnt), 2);
    wr_req = 1'b1;
    for (int i = 0; i < 65533; i++) tick();
    wr_req = 1'b0;
    #1;
    check("drop_cnt_max", 32'(drop_cnt), 32'hFFFF);
    wr_req = 1'b1;
    tick(); tick(); tick();
    wr_req = 1'b0;
    #1;
    check("drop_cnt_sat", 32'(drop_cnt), 32'hFFFF);
    idle_inputs();
    tick();

    // Reach WAIT_SWAP with front_buf=1, then reset asynchronously.
    raster_done = 1'b1; vblank = 1'b1;
    tick();
    raster_done = 1'b0;
    tick();
    vblank = 1'b0;
    #1;
    check("pre_rst_front", 32'(front_buf), 1);
    raster_done = 1'b1;
    tick();
    raster_done = 1'b0;
    #1;
    check("pre_rst_pend", 32'(swap_pending), 1);
    wr_req = 1'b1; disp_req = 1'b1;
    #2;
    rst = 1'b0;
    #1;
    check("arst_front",    32'(front_buf), 0);
    check("arst_pend",     32'(swap_pending), 0);
    check("arst_mem_en",   32'(mem_en), 0);
    check("arst_wr_ready", 32'(wr_ready), 0);
    check("arst_drop_cnt", 32'(drop_cnt), 0);
    tick();
    rst = 1'b1;
    idle_inputs();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
